// File: rtl/apb_pkg.sv
// Shared APB completer types and constants.
// Data/strobe widths, FSM state encoding and the read-only ID register index.
`timescale 1ns/1ps
package apb_pkg;

  localparam int APB_DW = 32;
  localparam int APB_SW = 4;
  localparam int ID_IDX = 0;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_slv_state_t;

endpackage

// File: rtl/apb_slv_regbank_mem.sv
// Register array: reg[0]=ID_VAL, others RESET_VAL on reset.
// Ports: clk, reset (sync, active-low), rd_idx/rd_data, we/wr_idx/wdata/wmask.
`timescale 1ns/1ps
module apb_slv_regbank_mem
  import apb_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter int          IW        = 4,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000,
  parameter logic [31:0] ID_VAL    = 32'hA9B0_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IW-1:0]     rd_idx,
  output logic [APB_DW-1:0] rd_data,
  input  logic              we,
  input  logic [IW-1:0]     wr_idx,
  input  logic [APB_DW-1:0] wdata,
  input  logic [APB_SW-1:0] wmask
);

  logic [APB_DW-1:0] regs_q [NUM_REGS];
  logic [APB_DW-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      for (int b = 0; b < APB_SW; b++) begin
        if (wmask[b]) begin
          regs_d[wr_idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == ID_IDX) ? ID_VAL : RESET_VAL;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_data = regs_q[rd_idx];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB3 completer: register bank behind a programmable wait-state FSM.
// Ports: clk, reset (sync, active-low), APB psel/penable/pwrite/paddr/pwdata/
// pstrb in, pready/prdata/pslverr out. APB_SLV_PSTRB_EN enables byte strobes.
`timescale 1ns/1ps
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000,
  parameter logic [31:0] ID_VAL      = 32'hA9B0_0001
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  input  logic [3:0]        pstrb_i,
  output logic              pready_o,
  output logic [31:0]       prdata_o,
  output logic              pslverr_o
);

  localparam int IW  = $clog2(NUM_REGS);
  localparam int AIW = ADDR_W - 2;
  localparam int CW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  apb_slv_state_t    state_q, state_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [APB_DW-1:0] wdata_q, wdata_d;
  logic [APB_DW-1:0] prdata_q, prdata_d;
  logic [APB_SW-1:0] wmask;
  logic [APB_DW-1:0] rd_data;
  logic [AIW-1:0]    a_idx;
  logic              err_c;
  logic              we;

`ifdef APB_SLV_PSTRB_EN
  logic [APB_SW-1:0] strb_q, strb_d;
  assign wmask = strb_q;
`else
  logic unused_strb;
  assign unused_strb = ^pstrb_i;
  assign wmask = '1;
`endif

  assign a_idx = paddr_i[ADDR_W-1:2];

  always_comb begin
    err_c = (32'(a_idx) >= NUM_REGS)
          | (paddr_i[1:0] != 2'b00)
          | (pwrite_i & (a_idx == AIW'(ID_IDX)));
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
    we       = 1'b0;
`ifdef APB_SLV_PSTRB_EN
    strb_d   = strb_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          idx_d    = paddr_i[IW+1:2];
          wr_d     = pwrite_i;
          wdata_d  = pwdata_i;
          wcnt_d   = CW'(WAIT_CYCLES);
          err_d    = err_c;
          prdata_d = (!pwrite_i && !err_c) ? rd_data : '0;
          state_d  = ACCESS;
`ifdef APB_SLV_PSTRB_EN
          strb_d   = pstrb_i;
`endif
        end
      end
      ACCESS: begin
        if (!psel_i) begin
          state_d = IDLE;
        end else if (penable_i) begin
          if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - CW'(1);
          end else begin
            we      = wr_q & ~err_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      prdata_q <= '0;
`ifdef APB_SLV_PSTRB_EN
      strb_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
`ifdef APB_SLV_PSTRB_EN
      strb_q   <= strb_d;
`endif
    end
  end

  apb_slv_regbank_mem #(
    .NUM_REGS (NUM_REGS),
    .IW       (IW),
    .RESET_VAL(RESET_VAL),
    .ID_VAL   (ID_VAL)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .rd_idx (paddr_i[IW+1:2]),
    .rd_data(rd_data),
    .we     (we),
    .wr_idx (idx_q),
    .wdata  (wdata_q),
    .wmask  (wmask)
  );

  assign pready_o  = (state_q == ACCESS) && (wcnt_q == '0);
  assign pslverr_o = pready_o & err_q;
  assign prdata_o  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Scoreboard bench for apb_slave_regbank: WAIT_CYCLES=2 and =0 instances.
// Stimulus pushes expected responses; a negedge monitor pops on pready.
`timescale 1ns/1ps
module tb_apb_slave_regbank;

  localparam logic [31:0] ID = 32'hA9B0_0001;
`ifdef APB_SLV_PSTRB_EN
  localparam logic [31:0] STRB_EXP = 32'h00BB_00DD;
`else
  localparam logic [31:0] STRB_EXP = 32'hAABB_CCDD;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        psel2 = 1'b0;
  logic        psel0 = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready2, pslverr2, pready0, pslverr0;
  logic [31:0] prdata2, prdata0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    string       nm;
  } exp_t;

  exp_t q2[$];
  exp_t q0[$];

  always #5 clk = ~clk;

  apb_slave_regbank #(.WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .psel_i(psel2), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
    .pstrb_i(pstrb), .pready_o(pready2), .prdata_o(prdata2),
    .pslverr_o(pslverr2)
  );

  apb_slave_regbank #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .psel_i(psel0), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
    .pstrb_i(pstrb), .pready_o(pready0), .prdata_o(prdata0),
    .pslverr_o(pslverr0)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon(input string dn, ref exp_t q[$],
                     input logic [31:0] rd, input logic err);
    exp_t e;
    if (q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s unexpected pready: got 1 want 0", dn);
    end else begin
      e = q.pop_front();
      chk({dn, " ", e.nm, " prdata"}, rd, e.rd);
      chk({dn, " ", e.nm, " pslverr"}, 32'(err), 32'(e.err));
    end
  endtask

  always @(negedge clk) begin
    if (pready2) mon("dut2", q2, prdata2, pslverr2);
    if (pready0) mon("dut0", q0, prdata0, pslverr0);
  end

  task automatic xfer(input int inst, input logic wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] erd, input logic eerr,
                      input string nm);
    exp_t e;
    int   cyc;
    e.rd  = erd;
    e.err = eerr;
    e.nm  = nm;
    if (inst == 2) q2.push_back(e);
    else q0.push_back(e);
    psel2   = (inst == 2);
    psel0   = (inst == 0);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr   = 8'h3C;
    pwdata  = ~d;
    cyc     = 1;
    while (((inst == 2) ? pready2 : pready0) == 1'b0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " access cycles"}, 32'(cyc), (inst == 2) ? 32'd3 : 32'd1);
    @(posedge clk); #1;
    psel2   = 1'b0;
    psel0   = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst pready2", 32'(pready2), 0);
    chk("rst prdata2", prdata2, 0);
    chk("rst pslverr2", 32'(pslverr2), 0);
    chk("rst pready0", 32'(pready0), 0);
    chk("rst prdata0", prdata0, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    xfer(2, 0, 8'h00, 0, 4'hF, ID, 0, "rd id");
    xfer(2, 1, 8'h08, 32'hDEADBEEF, 4'hF, 0, 0, "wr 08");
    xfer(2, 0, 8'h08, 0, 4'hF, 32'hDEADBEEF, 0, "rd 08");
    xfer(2, 0, 8'h04, 0, 4'hF, 0, 0, "rd 04");
    xfer(2, 1, 8'h00, 32'h12345678, 4'hF, 0, 1, "wr id err");
    xfer(2, 1, 8'h40, 32'h12345678, 4'hF, 0, 1, "wr idx16 err");
    xfer(2, 0, 8'h06, 0, 4'hF, 0, 1, "rd misalign err");
    xfer(2, 0, 8'h00, 0, 4'hF, ID, 0, "rd id again");

    psel2   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h0C;
    pwdata  = 32'h1234;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel2   = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
    chk("abort pready", 32'(pready2), 0);
    @(posedge clk); #1;
    xfer(2, 0, 8'h0C, 0, 4'hF, 0, 0, "rd 0C after abort");

    xfer(0, 1, 8'h10, 32'h11, 4'hF, 0, 0, "b2b wr 10");
    xfer(0, 0, 8'h10, 0, 4'hF, 32'h11, 0, "b2b rd 10");

    xfer(2, 1, 8'h14, 32'hAABBCCDD, 4'b0101, 0, 0, "wr 14 strb");
    xfer(2, 0, 8'h14, 0, 4'hF, STRB_EXP, 0, "rd 14 strb");

    psel2   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h18;
    pwdata  = 32'h55;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b0;
    @(posedge clk); #1;
    chk("mid rst pready", 32'(pready2), 0);
    chk("mid rst prdata", prdata2, 0);
    reset   = 1'b1;
    psel2   = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
    chk("post rst pready", 32'(pready2), 0);

    xfer(2, 0, 8'h08, 0, 4'hF, 0, 0, "rd 08 post rst");
    xfer(2, 0, 8'h14, 0, 4'hF, 0, 0, "rd 14 post rst");
    xfer(2, 0, 8'h18, 0, 4'hF, 0, 0, "rd 18 post rst");
    xfer(2, 0, 8'h00, 0, 4'hF, ID, 0, "rd id post rst");
    xfer(0, 0, 8'h10, 0, 4'hF, 0, 0, "rd 10 post rst");

    repeat (3) @(posedge clk);
    #1;
    chk("q2 drained", 32'(q2.size()), 0);
    chk("q0 drained", 32'(q0.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
- APB3-style completer (slave) that consumes the transfers driven by the APB_System requester.
- Holds a bank of 32-bit registers behind a programmable wait-state engine and returns pready/prdata/pslverr.
- Sits directly downstream of the APB requester; its prdata feeds back to the requester's rd_data_o path.

Parameters:
- ADDR_W, 8, byte-address width of paddr_i
- NUM_REGS, 16, number of 32-bit registers; word index = paddr_i[ADDR_W-1:2]
- WAIT_CYCLES, 2, wait states inserted per access phase (0 = zero-wait)
- RESET_VAL, 32'h0000_0000, reset value of registers 1..NUM_REGS-1
- ID_VAL, 32'hA9B0_0001, read-only contents of register 0

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- psel_i  in  1  APB select
- penable_i  in  1  APB enable (access phase)
- pwrite_i  in  1  1 = write, 0 = read
- paddr_i  in  ADDR_W  byte address
- pwdata_i  in  32  write data
- pstrb_i  in  4  byte strobes (used only with APB_SLV_PSTRB_EN)
- pready_o  out  1  transfer complete
- prdata_o  out  32  read data, valid when pready_o=1 and read
- pslverr_o  out  1  error response, valid when pready_o=1

Behaviour:
- Reset (reset=0 at an edge): FSM=IDLE, wait counter=0, pready_o=0, prdata_o=0, pslverr_o=0, reg[0]=ID_VAL, reg[1..]=RESET_VAL.
- FSM states: IDLE, ACCESS.
- IDLE: if psel_i=1 and penable_i=0 (setup phase), then at the edge:
  - latch addr, write flag and wdata;
  - load wait counter = WAIT_CYCLES;
  - compute err;
  - for a non-error read, capture prdata_o = reg[idx]; else prdata_o = 0;
  - go to ACCESS.
  - penable_i=1 seen in IDLE without a prior setup is ignored.
- ACCESS:
  - pready_o = (wcnt==0), decoded from flops only; pslverr_o = latched err while pready_o=1, else 0.
  - While psel_i=1, penable_i=1 and wcnt!=0: decrement wcnt.
  - Completion edge (pready_o=1, psel_i=1, penable_i=1): for a non-error write, commit reg[idx] <= wdata; go to IDLE.
  - Abort: psel_i=0 in ACCESS, at the edge → IDLE. No write commit, no response.
- Latency: access phase lasts WAIT_CYCLES+1 cycles; minimum 2 cycles per transfer. A back-to-back setup in the cycle after completion is accepted.
- Errors (err=1):
  - idx >= NUM_REGS
  - paddr_i[1:0] != 0
  - write to idx 0 (read-only ID)
  - An error write leaves every register unchanged; an error read returns prdata_o=0.
- Inputs pwdata_i and paddr_i are latched at setup; changes during ACCESS are ignored.
- reset=0 mid-ACCESS: immediate return to reset state; no pready_o pulse; the pending write is dropped.

Optional Feature:
- Macro APB_SLV_PSTRB_EN.
- Defined: writes update only byte lanes with pstrb_i[n]=1 (pstrb_i latched at setup). pstrb_i=4'b0000 on a write is a legal no-op with pslverr_o=0.
- Undefined: pstrb_i is ignored and every write updates all 32 bits.
- The port exists in both builds.

Decomposition:
- Package apb_pkg holds:
  - APB_DW=32 and APB_SW=4;
  - typedef enum logic {IDLE, ACCESS} apb_slv_state_t;
  - localparam for the ID register index (0).
- One sub-module, apb_slv_regbank_mem: register array with reset values, read port, and byte-masked write port.
- The FSM, wait counter and error decode stay in the top.

Test Plan:
- Reset, then read addr 0x00 with WAIT_CYCLES=2 → pready_o high on the 3rd access cycle, prdata_o=0xA9B0_0001, pslverr_o=0.
- Write 0xDEADBEEF to 0x08, then read 0x08 → prdata_o=0xDEADBEEF; read 0x04 → 0x0000_0000.
- Write to 0x00, write to 0x40 (idx 16), read 0x06 (misaligned) → each completes with pslverr_o=1. Reg 0 stays 0xA9B0_0001 and the read returns 0.
- Setup for a write of 0x1234 to 0x0C, then drop psel_i during the 2nd access cycle → no pready_o pulse; a later read of 0x0C returns 0.
- Back-to-back: write 0x11 to 0x10, then immediately read 0x10 with WAIT_CYCLES=0 → each transfer takes 2 cycles and the read returns 0x11. Assert reset=0 mid-access of a third write → pready_o stays 0 and all registers return to reset values.
- With APB_SLV_PSTRB_EN: write 0xAABBCCDD to 0x14 with pstrb_i=4'b0101 over an initial 0 → readback 0x00BB00DD. Without the macro, the same stimulus reads back 0xAABBCCDD.
